// File: rtl/sweep_instr_packer_if.sv
// rtl/sweep_instr_packer_if.sv - host byte stream and instruction FIFO write port bundle
// slave is the packer side, master is the host/FIFO side.
interface sweep_instr_packer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [87:0] fifo_wr_data;

  modport slave (
    input  in_data, in_valid, fifo_full,
    output in_ready, fifo_wr_en, fifo_wr_data
  );

  modport master (
    output in_data, in_valid, fifo_full,
    input  in_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/sweep_instr_packer.sv
// rtl/sweep_instr_packer.sv - frames host bytes into 88-bit sweep/PLL instruction words
// Optional trailing XOR checksum byte enabled by defining PACKER_CHECKSUM_EN.
module sweep_instr_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  sweep_instr_packer_if.slave  bus,
  output logic                 frame_ok_o,
  output logic                 frame_err_o,
  output logic [7:0]           err_count_o
);
  localparam int IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
`ifdef PACKER_CHECKSUM_EN
    CHECK   = 2'd2,
`endif
    WRITE   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [87:0]   asm_q, asm_d;
  logic [87:0]   word_q, word_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
`ifdef PACKER_CHECKSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic          accept;
  logic          expire;
  logic [87:0]   shifted;

  assign bus.in_ready     = !reset_i && (state_q != WRITE);
  assign bus.fifo_wr_en   = !reset_i && (state_q == WRITE) && !bus.fifo_full;
  assign bus.fifo_wr_data = word_q;
  assign frame_ok_o       = bus.fifo_wr_en;
  assign frame_err_o      = err_q;
  assign err_count_o      = cnt_q;

  assign accept  = bus.in_valid && bus.in_ready;
  // An accepted byte on the last idle cycle pre-empts the timeout.
  assign expire  = (idle_q == IDLE_LAST) && !accept;
  assign shifted = {asm_q[79:0], bus.in_data};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    word_d  = word_q;
    idle_d  = idle_q;
    err_d   = 1'b0;
`ifdef PACKER_CHECKSUM_EN
    xor_d   = xor_q;
`endif
    case (state_q)
      HUNT: begin
        idle_d = '0;
        if (accept && bus.in_data == SYNC_BYTE) begin
          state_d = PAYLOAD;
          idx_d   = 4'd0;
`ifdef PACKER_CHECKSUM_EN
          xor_d   = 8'h00;
`endif
        end
      end
      PAYLOAD: begin
        if (accept) begin
          asm_d  = shifted;
          idx_d  = idx_q + 4'd1;
          idle_d = '0;
`ifdef PACKER_CHECKSUM_EN
          xor_d  = xor_q ^ bus.in_data;
          if (idx_q == 4'd10) state_d = CHECK;
`else
          if (idx_q == 4'd10) begin
            if (shifted[86:80] != 7'd0) begin
              err_d   = 1'b1;
              state_d = HUNT;
            end else begin
              word_d  = shifted;
              state_d = WRITE;
            end
          end
`endif
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
`ifdef PACKER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          idle_d = '0;
          if (bus.in_data != xor_q || asm_q[86:80] != 7'd0) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            word_d  = asm_q;
            state_d = WRITE;
          end
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = HUNT;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
`endif
      WRITE: begin
        if (!bus.fifo_full) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
    cnt_d = (err_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= HUNT;
      idx_q   <= 4'd0;
      asm_q   <= '0;
      word_q  <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
`ifdef PACKER_CHECKSUM_EN
      xor_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef PACKER_CHECKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end
endmodule

// File: tb/tb_sweep_instr_packer.sv
// tb/tb_sweep_instr_packer.sv - directed self-checking bench for sweep_instr_packer
`timescale 1ns/1ps
module tb_sweep_instr_packer;
  localparam int unsigned T = 40;
`ifdef PACKER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam logic [87:0] GOOD = 88'h00_12345678_0010_00000100;
  localparam logic [87:0] RSV  = 88'h40_12345678_0010_00000100;
  localparam logic [87:0] W2   = 88'h80_00001000_0064_00000010;
  localparam logic [87:0] W3   = 88'h00_0BEBC200_03E8_00001000;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_count;
  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int wr_base;
  int bp_bad;

  sweep_instr_packer_if bus();

  sweep_instr_packer #(.TIMEOUT_CYCLES(T), .SYNC_BYTE(8'hA5)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .bus         (bus),
    .frame_ok_o  (frame_ok),
    .frame_err_o (frame_err),
    .err_count_o (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.fifo_wr_en) wr_cnt <= wr_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [87:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) send(w[87-8*i -: 8]);
  endtask

  task automatic send_ck(input logic [87:0] w);
`ifdef PACKER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 11; i++) x = x ^ w[87-8*i -: 8];
    send(x);
`else
    if (w[0] === 1'bx) tick();
`endif
  endtask

  task automatic send_frame(input logic [87:0] w);
    send(8'hA5);
    send_payload(w, 0, 10);
    send_ck(w);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.fifo_full = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 88'(bus.in_ready), 88'(0));
    chk("rst_wr_en", 88'(bus.fifo_wr_en), 88'(0));
    chk("rst_wr_data", bus.fifo_wr_data, 88'(0));
    chk("rst_frame_ok", 88'(frame_ok), 88'(0));
    chk("rst_frame_err", 88'(frame_err), 88'(0));
    chk("rst_err_count", 88'(err_count), 88'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 88'(bus.in_ready), 88'(1));

    send(8'h00); send(8'hFF); send(8'h3C);
    chk("garbage_err", 88'(err_count), 88'(0));
    send_frame(GOOD);
    chk("good_wr_en", 88'(bus.fifo_wr_en), 88'(1));
    chk("good_frame_ok", 88'(frame_ok), 88'(1));
    chk("good_wr_data", bus.fifo_wr_data, GOOD);
    chk("good_in_ready", 88'(bus.in_ready), 88'(0));
    tick();
    chk("good_wr_cnt", 88'(wr_cnt), 88'(1));
    chk("good_err_count", 88'(err_count), 88'(0));

`ifdef PACKER_CHECKSUM_EN
    send(8'hA5);
    send_payload(GOOD, 0, 10);
    send(8'h18);
    chk("badck_frame_err", 88'(frame_err), 88'(1));
    chk("badck_err_count", 88'(err_count), 88'(1));
    tick();
    chk("badck_err_pulse", 88'(frame_err), 88'(0));
    chk("badck_no_write", 88'(wr_cnt), 88'(1));
    send_frame(GOOD);
    tick();
    chk("after_badck_write", 88'(wr_cnt), 88'(2));
`endif

    wr_base = wr_cnt;
    send_frame(RSV);
    chk("rsv_frame_err", 88'(frame_err), 88'(1));
    chk("rsv_wr_en", 88'(bus.fifo_wr_en), 88'(0));
    chk("rsv_err_count", 88'(err_count), 88'(CK + 1));
    tick();
    chk("rsv_no_write", 88'(wr_cnt), 88'(wr_base));

    bus.fifo_full = 1'b1;
    send_frame(W2);
    bp_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready !== 1'b0 || bus.fifo_wr_en !== 1'b0) bp_bad++;
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_stall", 88'(bp_bad), 88'(0));
    chk("bp_no_write", 88'(wr_cnt), 88'(wr_base));
    bus.fifo_full = 1'b0;
    #1;
    chk("bp_release_wr_en", 88'(bus.fifo_wr_en), 88'(1));
    chk("bp_release_data", bus.fifo_wr_data, W2);
    tick();
    tick();
    chk("bp_single_write", 88'(wr_cnt), 88'(wr_base + 1));

    send(8'hA5);
    send_payload(W3, 0, 4);
    for (int i = 0; i < int'(T) - 1; i++) tick();
    chk("to_before_expiry", 88'(frame_err), 88'(0));
    tick();
    chk("to_frame_err", 88'(frame_err), 88'(1));
    chk("to_err_count", 88'(err_count), 88'(CK + 2));
    chk("to_data_hold", bus.fifo_wr_data, W2);

    wr_base = wr_cnt;
    send(8'hA5);
    send_payload(W3, 0, 4);
    for (int i = 0; i < int'(T) - 1; i++) tick();
    send_payload(W3, 5, 10);
    send_ck(W3);
    chk("towin_wr_en", 88'(bus.fifo_wr_en), 88'(1));
    chk("towin_data", bus.fifo_wr_data, W3);
    tick();
    chk("towin_err_count", 88'(err_count), 88'(CK + 2));
    chk("towin_wr_cnt", 88'(wr_cnt), 88'(wr_base + 1));

    for (int i = 0; i < 260; i++) send_frame(RSV);
    tick();
    chk("err_saturate", 88'(err_count), 88'(255));

    wr_base = wr_cnt;
    send(8'hA5);
    send_payload(GOOD, 0, 5);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 88'(bus.in_ready), 88'(0));
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_err_count", 88'(err_count), 88'(0));
    send_frame(GOOD);
    chk("midrst_resync_data", bus.fifo_wr_data, GOOD);
    tick();
    chk("midrst_wr_cnt", 88'(wr_cnt), 88'(wr_base + 1));

    bus.fifo_full = 1'b1;
    send_frame(W2);
    tick();
    reset = 1'b1;
    bus.fifo_full = 1'b0;
    #1;
    chk("wrrst_wr_en", 88'(bus.fifo_wr_en), 88'(0));
    tick();
    reset = 1'b0;
    tick();
    chk("wrrst_no_write", 88'(wr_cnt), 88'(wr_base + 1));
    chk("wrrst_data_cleared", bus.fifo_wr_data, 88'(0));
    chk("wrrst_in_ready", 88'(bus.in_ready), 88'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
